// File: rtl/ysyx_040750_hazard_ctrl.sv
// rtl/ysyx_040750_hazard_ctrl.sv - pipeline hazard controller with shadow scoreboard
//
// Purpose: shadows {rd, wen, load} of the EX/MEM/WB instructions, produces
// rs1/rs2 match vectors and write-enables for the forward unit, inserts
// load-use bubbles, and applies memory-stall freeze and branch-flush kill.
//
// Optional feature macro: YSYX_040750_HAZARD_PERF_EN (adds perf counters).
//
// Ports:
//   I_sys_clk, I_rst          clock, synchronous active-high reset
//   I_ID_*                    decoded operands of the instruction in ID
//   I_mem_stall, I_flush      memory not ready / branch redirect
//   O_{EX,MEM,WB}_stall       {rs1 match, rs2 match} per stage
//   O_{EX,MEM,WB}_reg_wen     scoreboard write-enable per stage
//   O_PC_hold, O_ID_EX_bubble, O_pipe_freeze   pipeline control
//   O_luse_cnt, O_freeze_cnt  perf counters (macro defined only)
module ysyx_040750_hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int LOAD_USE_CYC = 1
) (
  input  logic              I_sys_clk,
  input  logic              I_rst,
  input  logic              I_ID_valid,
  input  logic [REG_AW-1:0] I_ID_rs1,
  input  logic [REG_AW-1:0] I_ID_rs2,
  input  logic              I_ID_rs1_en,
  input  logic              I_ID_rs2_en,
  input  logic [REG_AW-1:0] I_ID_rd,
  input  logic              I_ID_reg_wen,
  input  logic              I_ID_is_load,
  input  logic              I_mem_stall,
  input  logic              I_flush,
  output logic [1:0]        O_EX_stall,
  output logic [1:0]        O_MEM_stall,
  output logic [1:0]        O_WB_stall,
  output logic              O_EX_reg_wen,
  output logic              O_MEM_reg_wen,
  output logic              O_WB_reg_wen,
  output logic              O_PC_hold,
  output logic              O_ID_EX_bubble,
`ifdef YSYX_040750_HAZARD_PERF_EN
  output logic [31:0]       O_luse_cnt,
  output logic [31:0]       O_freeze_cnt,
`endif
  output logic              O_pipe_freeze
);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic              load;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;
  localparam logic [1:0] BCNT_RELOAD = 2'(LOAD_USE_CYC - 1);

  sb_entry_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [1:0] bcnt_q, bcnt_d;
  logic       luse, stall_req, issue;

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic [1:0] match(input sb_entry_t e);
    logic m1, m2;
    m1 = I_ID_rs1_en & e.wen & (e.rd == I_ID_rs1) & (I_ID_rs1 != '0);
    m2 = I_ID_rs2_en & e.wen & (e.rd == I_ID_rs2) & (I_ID_rs2 != '0);
    return {m1, m2};
  endfunction

  always_comb begin
    O_EX_stall    = match(ex_q);
    O_MEM_stall   = match(mem_q);
    O_WB_stall    = match(wb_q);
    O_EX_reg_wen  = ex_q.wen;
    O_MEM_reg_wen = mem_q.wen;
    O_WB_reg_wen  = wb_q.wen;

    luse      = I_ID_valid & ex_q.wen & ex_q.load & (O_EX_stall != 2'b00);
    stall_req = luse | (bcnt_q != 2'd0);
    issue     = I_ID_valid & ~stall_req & ~I_flush;

    O_pipe_freeze  = I_mem_stall;
    O_PC_hold      = stall_req & ~I_flush & ~I_mem_stall;
    O_ID_EX_bubble = (stall_req | I_flush) & ~I_mem_stall;
  end

  always_comb begin
    ex_d   = ex_q;
    mem_d  = mem_q;
    wb_d   = wb_q;
    bcnt_d = bcnt_q;
    if (!I_mem_stall) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = issue ? '{rd: I_ID_rd, wen: I_ID_reg_wen, load: I_ID_is_load} : SB_EMPTY;
      // A flush kills the consumer, so the extra bubbles are not needed.
      if (luse && (bcnt_q == 2'd0) && !I_flush) begin
        bcnt_d = BCNT_RELOAD;
      end else if (bcnt_q != 2'd0) begin
        bcnt_d = bcnt_q - 2'd1;
      end
    end
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      ex_q   <= SB_EMPTY;
      mem_q  <= SB_EMPTY;
      wb_q   <= SB_EMPTY;
      bcnt_q <= 2'd0;
    end else begin
      ex_q   <= ex_d;
      mem_q  <= mem_d;
      wb_q   <= wb_d;
      bcnt_q <= bcnt_d;
    end
  end

`ifdef YSYX_040750_HAZARD_PERF_EN
  logic [31:0] luse_cnt_q, freeze_cnt_q;

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      luse_cnt_q   <= 32'd0;
      freeze_cnt_q <= 32'd0;
    end else begin
      if (O_PC_hold)   luse_cnt_q   <= luse_cnt_q + 32'd1;
      if (I_mem_stall) freeze_cnt_q <= freeze_cnt_q + 32'd1;
    end
  end

  assign O_luse_cnt   = luse_cnt_q;
  assign O_freeze_cnt = freeze_cnt_q;
`endif

endmodule
